// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states, memory depth.
package mem_access_pkg;

  localparam int MEM_WORDS_DEFAULT = 1024;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP,
    ST_ERR
  } state_e;

endpackage

// File: rtl/lane_merge.sv
// Little-endian lane logic: extracts and extends a load lane, and merges a store lane into an old word.
module lane_merge
  import mem_access_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] ext_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd_word[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ext_data = rd_word;
    merged   = old_word;
    case (size)
      SZ_BYTE: begin
        ext_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ext_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-only DataMemory.
// Sub-word stores run as read-modify-write; bad requests are rejected without touching memory.
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | ready for a request
// ST_LOAD   | MemRead, capture extended lane into resp_rdata
// ST_STORE  | MemWrite of the full store word
// ST_RMW_RD | MemRead, capture old word into merge register
// ST_RMW_WR | MemWrite of merged word
// ST_RESP   | resp_valid pulse, no error
// ST_ERR    | resp_valid pulse with resp_err
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_bad;
  logic [31:0] ext_data;
  logic [31:0] merged;

  lane_merge u_lane_merge (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .rd_word     (ReadData),
    .old_word    (merge_q),
    .wdata       (wdata_q),
    .ext_data    (ext_data),
    .merged      (merged)
  );

  always_comb begin
    case (req_size)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = req_addr[0];
      SZ_WORD: req_bad = |req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS_L) req_bad = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          wdata_d    = req_wdata;
          if (req_bad)                 state_d = ST_ERR;
          else if (!req_write)         state_d = ST_LOAD;
          else if (req_size == SZ_WORD) state_d = ST_STORE;
          else                         state_d = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        rdata_d = ext_data;
        state_d = ST_RESP;
      end
      ST_STORE:  state_d = ST_RESP;
      ST_RMW_RD: begin
        merge_d = ReadData;
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR: state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      merge_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
      merge_q    <= merge_d;
      rdata_q    <= rdata_d;
    end
  end

  // Strobes are gated by rst_n so a reset asserted mid-write suppresses the commit edge.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign resp_err   = (state_q == ST_ERR);
  assign resp_rdata = rdata_q;
  assign MemRead    = rst_n && ((state_q == ST_LOAD) || (state_q == ST_RMW_RD));
  assign MemWrite   = rst_n && ((state_q == ST_STORE) || (state_q == ST_RMW_WR));
  assign Address    = {addr_q[31:2], 2'b00};
  assign WriteData  = (state_q == ST_STORE)  ? wdata_q :
                      (state_q == ST_RMW_WR) ? merged  : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-wide DataMemory.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData, ReadData;

  logic [31:0] mem [0:1023];
  logic        tb_we;
  logic [9:0]  tb_idx;
  logic [31:0] tb_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
  );

  assign ReadData = mem[Address[11:2]];

  always @(posedge clk) begin
    if (MemWrite) mem[Address[11:2]] <= WriteData;
    if (tb_we)    mem[tb_idx] <= tb_data;
  end

  task automatic poke(input int idx, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_idx = idx[9:0]; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output int nrd, output int nwr,
                        output logic err, output logic [31:0] rdata, output logic [31:0] waddr);
    lat = 0; nrd = 0; nwr = 0; err = 1'b0; rdata = '0; waddr = '0;
    @(negedge clk);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (MemRead) nrd++;
      if (MemWrite) begin nwr++; waddr = Address; end
      if (resp_valid) begin lat = k; err = resp_err; rdata = resp_rdata; break; end
    end
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp: got v=%b e=%b want 0 0", resp_valid, resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    checks++; if (MemRead !== 1'b0 || MemWrite !== 1'b0) begin errors++; $display("FAIL reset_strobes: got r=%b w=%b want 0 0", MemRead, MemWrite); end
    checks++; if (Address !== 32'h0 || WriteData !== 32'h0) begin errors++; $display("FAIL reset_bus: got a=%h wd=%h want 0 0", Address, WriteData); end
  endtask

  task automatic test_word();
    int lat, nrd, nwr; logic err; logic [31:0] rd, wa;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, lat, nrd, nwr, err, rd, wa);
    checks++; if (lat !== 2 || err !== 1'b0) begin errors++; $display("FAIL sw_latency: got lat=%0d err=%b want 2 0", lat, err); end
    checks++; if (nwr !== 1 || nrd !== 0 || wa !== 32'h10) begin errors++; $display("FAIL sw_strobe: got wr=%0d rd=%0d addr=%h want 1 0 00000010", nwr, nrd, wa); end
    @(negedge clk);
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem: got %h want deadbeef", mem[4]); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, nrd, nwr, err, rd, wa);
    checks++; if (lat !== 2 || nrd !== 1 || nwr !== 0) begin errors++; $display("FAIL lw_timing: got lat=%0d rd=%0d wr=%0d want 2 1 0", lat, nrd, nwr); end
    checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin errors++; $display("FAIL lw_data: got %h err=%b want deadbeef 0", rd, err); end
  endtask

  task automatic test_sub_load();
    int lat, nrd, nwr; logic err; logic [31:0] rd, wa;
    logic [31:0] addrs [5] = '{32'h13, 32'h13, 32'h11, 32'h12, 32'h10};
    logic [1:0]  szs   [5] = '{SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF};
    logic        unss  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] exps  [5] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01};
    poke(4, 32'h80FF7F01);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, szs[i], unss[i], addrs[i], 32'h0, lat, nrd, nwr, err, rd, wa);
      checks++;
      if (rd !== exps[i] || lat !== 2 || err !== 1'b0 || nrd !== 1)
        begin errors++; $display("FAIL sub_load_%0d: got %h lat=%0d err=%b rd=%0d want %h 2 0 1", i, rd, lat, err, nrd, exps[i]); end
    end
  endtask

  task automatic test_rmw();
    int lat, nrd, nwr; logic err; logic [31:0] rd, wa;
    poke(4, 32'h11223344);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'hFFFFFFAB, lat, nrd, nwr, err, rd, wa);
    checks++; if (lat !== 3 || nrd !== 1 || nwr !== 1 || wa !== 32'h10) begin errors++; $display("FAIL sb_timing: got lat=%0d rd=%0d wr=%0d a=%h want 3 1 1 00000010", lat, nrd, nwr, wa); end
    checks++; if (rd !== 32'h00007F01) begin errors++; $display("FAIL sb_rdata_hold: got %h want 00007f01", rd); end
    @(negedge clk);
    checks++; if (mem[4] !== 32'h11AB3344) begin errors++; $display("FAIL sb_mem: got %h want 11ab3344", mem[4]); end
    do_req(1'b1, SZ_HALF, 1'b0, 32'h10, 32'h1234CAFE, lat, nrd, nwr, err, rd, wa);
    do_req(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000BEEF, lat, nrd, nwr, err, rd, wa);
    @(negedge clk);
    checks++; if (mem[4] !== 32'hBEEFCAFE || lat !== 3) begin errors++; $display("FAIL sh_mem: got %h lat=%0d want beefcafe 3", mem[4], lat); end
  endtask

  task automatic test_errors();
    int lat, nrd, nwr; logic err; logic [31:0] rd, wa;
    logic [31:0] addrs [4] = '{32'h11, 32'h16, 32'h1000, 32'h10};
    logic [1:0]  szs   [4] = '{SZ_HALF, SZ_WORD, SZ_WORD, 2'b11};
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, szs[i], 1'b0, addrs[i], 32'h0, lat, nrd, nwr, err, rd, wa);
      checks++;
      if (lat !== 1 || err !== 1'b1 || nrd !== 0 || nwr !== 0)
        begin errors++; $display("FAIL err_%0d: got lat=%0d err=%b rd=%0d wr=%0d want 1 1 0 0", i, lat, err, nrd, nwr); end
    end
    do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, lat, nrd, nwr, err, rd, wa);
    checks++; if (lat !== 1 || err !== 1'b1 || nwr !== 0) begin errors++; $display("FAIL err_store: got lat=%0d err=%b wr=%0d want 1 1 0", lat, err, nwr); end
    poke(1023, 32'h0BADF00D);
    do_req(1'b0, SZ_WORD, 1'b0, 32'hFFC, 32'h0, lat, nrd, nwr, err, rd, wa);
    checks++; if (lat !== 2 || err !== 1'b0 || rd !== 32'h0BADF00D) begin errors++; $display("FAIL last_word: got lat=%0d err=%b d=%h want 2 0 0badf00d", lat, err, rd); end
  endtask

  task automatic test_reset_rmw();
    poke(8, 32'h12345678);
    @(negedge clk);
    req_write = 1'b1; req_size = SZ_HALF; req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'h0000BEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (MemRead !== 1'b1) begin errors++; $display("FAIL rst_rmw_rd: got MemRead=%b want 1", MemRead); end
    @(negedge clk);
    checks++; if (MemWrite !== 1'b1 || WriteData !== 32'h1234BEEF) begin errors++; $display("FAIL rst_rmw_wr: got w=%b wd=%h want 1 1234beef", MemWrite, WriteData); end
    rst_n = 1'b0;
    #1;
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL rst_drop_write: got %b want 0", MemWrite); end
    @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mem[8] !== 32'h12345678) begin errors++; $display("FAIL rst_mem: got %h want 12345678", mem[8]); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    int acc = 0, acc_at_r1 = 0, nresp = 0, extra = 0, t = 0, t1 = 0, t2 = 0;
    logic [31:0] r1 = '0, r2 = '0;
    poke(5, 32'hA5A5A5A5);
    poke(6, 32'h5A5A5A5A);
    @(negedge clk);
    req_write = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h14; req_valid = 1'b1;
    for (int k = 0; k < 20 && nresp < 2; k++) begin
      if (req_valid && req_ready) acc++;
      @(negedge clk);
      t++;
      if (resp_valid) begin
        nresp++;
        if (nresp == 1) begin r1 = resp_rdata; t1 = t; acc_at_r1 = acc; req_addr = 32'h18; end
        else begin r2 = resp_rdata; t2 = t; req_valid = 1'b0; end
      end
    end
    repeat (4) begin
      if (req_valid && req_ready) acc++;
      @(negedge clk);
      if (resp_valid) extra++;
    end
    checks++; if (nresp !== 2 || extra !== 0) begin errors++; $display("FAIL b2b_count: got %0d+%0d responses want 2+0", nresp, extra); end
    checks++; if (acc_at_r1 !== 1 || acc !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d/%0d want 1/2", acc_at_r1, acc); end
    checks++; if (r1 !== 32'hA5A5A5A5 || r2 !== 32'h5A5A5A5A) begin errors++; $display("FAIL b2b_data: got %h %h want a5a5a5a5 5a5a5a5a", r1, r2); end
    checks++; if (t1 !== 2 || t2 - t1 !== 3) begin errors++; $display("FAIL b2b_spacing: got first=%0d gap=%0d want 2 3", t1, t2 - t1); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_BYTE; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; tb_we = 1'b0; tb_idx = '0; tb_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_word();
    test_sub_load();
    test_rmw();
    test_errors();
    test_reset_rmw();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the pipeline MEM stage and `DataMemory`. It accepts one byte, halfword or word request at a time and drives the word-only `MemRead`/`MemWrite`/`Address`/`WriteData` interface. Sub-word loads are extracted and sign- or zero-extended; sub-word stores run as a read-modify-write. Misaligned and out-of-range requests are rejected before any memory access.

## Interface
- `MEM_WORDS`, default 1024: depth of `DataMemory` in words; the word index must be below this value.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept; high only in IDLE.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 half, 10 word; 11 is illegal and raises `resp_err`.
- `req_unsigned` input 1: zero-extend a sub-word load (lbu/lhu).
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data; the low byte or half is used for sub-word stores.
- `resp_valid` output 1: one-cycle pulse that completes a request.
- `resp_rdata` output 32: load result; held until the next `resp_valid`.
- `resp_err` output 1: qualifies `resp_valid`; set for misaligned, out-of-range or illegal-size requests.
- `MemRead`, `MemWrite` output 1: strobes to `DataMemory`.
- `Address` output 32: word-aligned (`[1:0]` = 00); driven from the latched request.
- `WriteData` output 32: full word to write.
- `ReadData` input 32: combinational read data from `DataMemory`; valid while `MemRead` = 1.

## Operation
- Handshake: a request is accepted on a rising edge where `req_valid` and `req_ready` are both 1. At acceptance the unit latches addr, size, write, unsigned and wdata.
- Error check, done at acceptance:
  - half with `addr[0]` = 1 is an error;
  - word with `addr[1:0]` ≠ 0 is an error;
  - `addr[31:2]` ≥ `MEM_WORDS` is an error;
  - `req_size` = 11 is an error.
  - On error, go to RESP with `resp_err` = 1 and no memory strobe.
- Byte lanes are little-endian. Byte offset k maps to bits `[8k+7:8k]`. Half offset 0 maps to `[15:0]`; offset 2 maps to `[31:16]`.
- States and transitions:
  - IDLE to ERR, LOAD, STORE or RMW_RD, depending on the error check and the request type.
  - LOAD: `MemRead` = 1. Capture the extracted, extended lane into `resp_rdata`. Go to RESP.
  - STORE (word store only): `MemWrite` = 1, `WriteData` = wdata. Go to RESP.
  - RMW_RD: `MemRead` = 1. Capture `ReadData` into the merge register. Go to RMW_WR.
  - RMW_WR: `MemWrite` = 1. `WriteData` = merge register with the target lane replaced. Go to RESP.
  - RESP / ERR: `resp_valid` = 1 for one cycle. Return to IDLE.
- `MemRead` and `MemWrite` are decoded from the state register only; they are never both 1. Both are forced to 0 while `rst_n` = 0.
- Stores leave `resp_rdata` unchanged.

## Timing
- Accept at edge N. `resp_valid` is high in cycle:
  - N+2 for word load and word store;
  - N+3 for sub-word store;
  - N+1 for an error.
- `req_ready` is low from cycle N+1 until the cycle after `resp_valid`. Back-to-back throughput is therefore one request per 3 cycles for word accesses.
- The `DataMemory` write commits at the rising edge that ends STORE or RMW_WR.
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_err` 0, `resp_rdata` 0, `MemRead` 0, `MemWrite` 0, `Address` 0, `WriteData` 0.
- Reset during RMW_RD aborts with no write. Reset during STORE or RMW_WR drops `MemWrite` immediately, so no write occurs if `rst_n` is low at the edge.
- `req_valid` is ignored while `req_ready` = 0; no queuing.

## Structure
- Shared package `mem_access_pkg` contains:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the state enum/localparams;
  - a default for `MEM_WORDS`.
- Sub-module `lane_merge` is combinational and covers both directions:
  - extract: addr[1:0], size, unsigned and word in, extended value out;
  - merge: addr[1:0], size, old word and wdata in, new word out.
- The top level holds the FSM and the request/merge registers.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x10, then load word from 0x10. Required: `MemWrite` pulse with `Address` = 0x10; `resp_rdata` = 0xDEADBEEF at N+2 of the load.
- Byte load sign/zero: memory word 0x10 = 0x80FF7F01. lb from 0x13 returns 0xFFFFFF80; lbu from 0x13 returns 0x00000080; lb from 0x11 returns 0x0000007F.
- Byte store RMW: word 0x10 = 0x11223344, then sb 0xAB at 0x12. Required: memory = 0x11AB3344; one `MemRead` cycle then one `MemWrite` cycle; `resp_valid` at N+3.
- Misalign/range: lh at 0x11, lw at 0x16, and lw at 0x1000 with `MEM_WORDS` = 1024. Each gives `resp_valid` = 1 and `resp_err` = 1 at N+1, and `MemRead`/`MemWrite` stay 0.
- Reset mid-RMW: sh 0xBEEF at 0x20 (word = 0x12345678). Assert `rst_n` low during RMW_WR, before the edge. Required: memory still 0x12345678; all outputs at reset values; `req_ready` = 1.
- Back-to-back: `req_valid` held high with two loads queued. The second is accepted only after the first `resp_valid`; no request is dropped or duplicated.
